// File: rtl/exec_pkg.sv
// Shared constants and types for the execute-unit issue scheduler.
package exec_pkg;

  // addi x0,x0,0: targets x0, so the always-on regfile write is harmless
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_RW = 7'b0111011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_IW = 7'b0011011;

  localparam int EXEC_XLEN  = 64;
  localparam int EXEC_TAG_W = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } sched_state_t;

  // Result FIFO entry layout at the default widths; the top packs the same
  // field order so wider/narrower parameterisations stay consistent.
  typedef struct packed {
    logic [EXEC_XLEN-1:0]  data;
    logic [4:0]            rd;
    logic [EXEC_TAG_W-1:0] tag;
    logic                  err;
  } res_entry_t;

  function automatic logic is_supported(input logic [6:0] opcode);
    return (opcode == OP_R) || (opcode == OP_RW) ||
           (opcode == OP_I) || (opcode == OP_IW);
  endfunction

endpackage

// File: rtl/exec_result_fifo.sv
// Synchronous result FIFO with clear; DEPTH must be a power of two >= 2.
module exec_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   clear_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy tracking; clear drops everything including a same-cycle pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care while empty so it carries no reset
  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/exec_issue_scheduler.sv
// Issues one instruction per cycle into core_execute_unit, filters opcodes,
// and queues each result with rd/tag for a valid/ready consumer.
module exec_issue_scheduler
  import exec_pkg::*;
#(
  parameter int XLEN      = EXEC_XLEN,
  parameter int TAG_W     = EXEC_TAG_W,
  parameter int RES_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic [31:0]      eu_instr,
  input  logic [XLEN-1:0]  eu_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [XLEN-1:0]  res_data,
  output logic [4:0]       res_rd,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_err,
  output logic             busy,
  output logic [15:0]      reject_cnt
);

  localparam int ENTRY_W = XLEN + 5 + TAG_W + 1;
  localparam int CNT_W   = $clog2(RES_DEPTH) + 1;

  sched_state_t     state_q;
  logic [15:0]      reject_cnt_q;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [ENTRY_W-1:0] push_entry, head_entry;
  logic [XLEN-1:0]  push_data;
  logic             supported, ready_int, fire_int, pop, fills_fifo;

  assign supported = is_supported(in_instr[6:0]);

  // ready_int drives only flops, which are held during reset anyway; rst
  // gates just the visible outputs so it never enters a synchronous path.
  assign ready_int = (state_q == RUN) && !fifo_full && !flush;
  assign fire_int  = in_valid && ready_int;
  assign in_ready  = rst && ready_int;
  assign eu_instr  = (rst && fire_int && supported) ? in_instr : NOP_INSTR;

  assign push_data  = supported ? eu_result : {XLEN{1'b0}};
  assign push_entry = {push_data, in_instr[11:7], in_tag, !supported};

  // flush discards any coincident pop
  assign pop        = res_ready && !fifo_empty && !flush;
  assign fills_fifo = fire_int && !pop && (fifo_count == CNT_W'(RES_DEPTH - 1));

  exec_result_fifo #(
    .DEPTH (RES_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_res_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (fire_int),
    .pop_i   (pop),
    .clear_i (flush),
    .wdata_i (push_entry),
    .rdata_o (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign res_valid = !fifo_empty;
  assign {res_data, res_rd, res_tag, res_err} = fifo_empty ? {ENTRY_W{1'b0}} : head_entry;
  assign busy       = !fifo_empty || (state_q != RUN);
  assign reject_cnt = reject_cnt_q;

  // Issue-control FSM: HOLD once the FIFO fills, FLUSH for one cycle after a flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (flush)           state_q <= FLUSH;
          else if (fills_fifo) state_q <= HOLD;
        end
        HOLD: begin
          if (flush)    state_q <= FLUSH;
          else if (pop) state_q <= RUN;
        end
        FLUSH:   state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  // Saturating count of accepted instructions with unsupported opcodes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reject_cnt_q <= 16'd0;
    end else if (fire_int && !supported && (reject_cnt_q != 16'hFFFF)) begin
      reject_cnt_q <= reject_cnt_q + 16'd1;
    end
  end

endmodule
